memory_arbiter: RTL and testbench

Sits directly downstream of the cache block, between the icache/dcache miss ports and the single-ported RAM. Serialises instruction-fetch and data read/write requests onto one RAM port. Data requests have fixed priority, with a starvation guard that forces an instruction grant after a bounded run of data grants. Drives the per-requester wait signals the caches use as completion handshakes.

---
 rtl/memory_arbiter.sv | 128 ++++++++++++
 tb/tb_memory_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Serialises icache reads and dcache reads/writes onto one single-ported RAM.
// The dcache has fixed priority. A starvation guard forces an icache grant
// after STARVE_MAX consecutive dcache grants that were issued while iREN
// was pending.
//
// Ports:
//   CLK, RST              clock; synchronous active-high reset
//   iREN, iaddr           icache read request (level, held until iwait low)
//   iwait, iload          icache completion handshake (low one cycle) and data
//   dREN, dWEN            dcache read/write request (dWEN wins over dREN)
//   daddr, dstore         dcache address and write data
//   dwait, dload          dcache completion handshake (low one cycle) and data
//   ramREN, ramWEN        RAM read/write command
//   ramaddr, ramstore     RAM address and write data
//   ramload, ram_ready    RAM read data and completion strobe
module memory_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic          iwait,
  output logic [DW-1:0] iload,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          dwait,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic          ram_ready
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] starve_cnt, starve_n;
  logic          dreq;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
    end
  end

  always_comb begin
    state_n  = state;
    starve_n = starve_cnt;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state)
      IDLE: begin
        if (dreq && ((starve_cnt < SMAX) || !iREN)) begin
          state_n = DGNT;
          // Only grants that pass over a pending icache request count
          // towards starvation.
          if (iREN) begin
            starve_n = (starve_cnt == SMAX) ? SMAX : starve_cnt + CW'(1);
          end else begin
            starve_n = '0;
          end
        end else if (iREN) begin
          state_n  = IGNT;
          starve_n = '0;
        end
      end

      IGNT: begin
        ramaddr = iaddr;
        // Command is qualified by the live request so a dropped request
        // aborts without issuing anything further to the RAM.
        if (!iREN) begin
          state_n = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ram_ready) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_n = IDLE;
          end
        end
      end

      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          state_n = IDLE;
        end else begin
          ramWEN = dWEN;
          ramREN = dREN & ~dWEN;
          if (ram_ready) begin
            dwait   = 1'b0;
            dload   = dWEN ? '0 : ramload;
            state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  localparam int SM = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  memory_arbiter #(.STARVE_MAX(SM), .AW(32), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: actual timeout/unexpected required handshake (cycle %0d)", name, cyc);
  endtask

  // RAM content is a fixed function of address; 0x40 holds the test pattern.
  function automatic logic [31:0] ramfn(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  typedef struct { logic [31:0] addr; logic [31:0] data; } iexp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } dexp_t;
  typedef struct { int cyc; bit isd; } log_t;

  iexp_t iq[$];
  dexp_t dq[$];
  log_t  clog[$];

  // RAM model knobs
  int lat = 1;
  bit rand_lat = 0;
  bit force_ready = 0;
  bit noise = 0;

  initial begin
    bit active;
    int cnt;
    int cur_lat;
    active = 0; cnt = 0; cur_lat = 0;
    ram_ready = 1'b0;
    ramload = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (ramREN | ramWEN) begin
        if (!active) begin
          active = 1; cnt = 0;
          cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
        end else cnt++;
        ram_ready = force_ready || (cnt >= cur_lat);
      end else begin
        active = 0;
        ram_ready = force_ready || (noise && ($urandom_range(0, 3) == 0));
      end
      ramload = ram_ready ? ramfn(ramaddr) : $urandom;
    end
  end

  // Monitor / scoreboard
  initial begin
    bit cmd_prev, dreq_prev, iren_prev, rst_prev, comp_prev;
    int streak;
    cmd_prev = 0; dreq_prev = 0; iren_prev = 0; rst_prev = 1; comp_prev = 0; streak = 0;
    forever begin
      bit cmd, dreq, comp, isd, expd;
      @(negedge CLK);
      cmd  = ramREN | ramWEN;
      dreq = dREN | dWEN;
      comp = 0;
      if (iwait === 1'b1) chk("iload_zero", iload, 32'h0);
      if (dwait === 1'b1) chk("dload_zero", dload, 32'h0);
      chk("waits_exclusive", {31'h0, iwait | dwait}, 32'h1);
      if (iwait === 1'b0) begin
        comp = 1;
        clog.push_back('{cyc, 1'b0});
        if (iq.size() == 0) fail_now("i_unexpected_completion");
        else begin
          iexp_t e;
          e = iq.pop_front();
          chk("i_ramaddr", ramaddr, e.addr);
          chk("i_load", iload, e.data);
          chk("i_cmd", {30'h0, ramWEN, ramREN}, 32'h1);
        end
      end
      if (dwait === 1'b0) begin
        comp = 1;
        clog.push_back('{cyc, 1'b1});
        if (dq.size() == 0) fail_now("d_unexpected_completion");
        else begin
          dexp_t e;
          e = dq.pop_front();
          chk("d_ramaddr", ramaddr, e.addr);
          if (e.wr) begin
            chk("d_wr_cmd", {30'h0, ramWEN, ramREN}, 32'h2);
            chk("d_ramstore", ramstore, e.data);
            chk("d_wr_load", dload, 32'h0);
          end else begin
            chk("d_rd_cmd", {30'h0, ramWEN, ramREN}, 32'h1);
            chk("d_load", dload, e.data);
          end
        end
      end
      if (comp_prev) chk("bubble", {31'h0, cmd}, 32'h0);
      // Arbitration rule applied at each new grant, using the request
      // levels from the preceding (arbitration) cycle.
      if (cmd && !cmd_prev && !rst_prev) begin
        isd  = dreq && (ramaddr == daddr);
        expd = dreq_prev && ((streak < SM) || !iren_prev);
        chk("arb_winner_is_d", {31'h0, isd}, {31'h0, expd});
        if (expd) streak = iren_prev ? ((streak < SM) ? streak + 1 : SM) : 0;
        else streak = 0;
      end
      if (RST) streak = 0;
      cmd_prev = cmd; dreq_prev = dreq; iren_prev = iREN;
      rst_prev = RST; comp_prev = comp;
    end
  end

  int last_i_req = 0;

  // Tasks start and end at posedge+#1.
  task automatic i_txn(input logic [31:0] a);
    bit done;
    iq.push_back('{a, ramfn(a)});
    iaddr = a; iREN = 1'b1; last_i_req = cyc;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge CLK);
      if (iwait === 1'b0) done = 1;
    end
    if (!done) fail_now("i_timeout");
    @(posedge CLK); #1;
    iREN = 1'b0;
  endtask

  task automatic d_txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    bit done;
    dq.push_back('{wr, a, wr ? d : ramfn(a)});
    dWEN = wr; dREN = rd; daddr = a; dstore = d;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge CLK);
      if (dwait === 1'b0) done = 1;
    end
    if (!done) fail_now("d_timeout");
    @(posedge CLK); #1;
    dREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic chk_idle(input string name);
    chk(name, {28'h0, ramREN, ramWEN, iwait, dwait}, 32'h3);
    chk({name, "_loads"}, iload | dload, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit expv [6];
    expv = '{1, 1, 1, 1, 0, 1};
    RST = 1'b1; iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_idle("reset_state");
    chk("reset_ramaddr", ramaddr, 32'h0);
    chk("reset_ramstore", ramstore, 32'h0);
    next_cycle();
    RST = 1'b0;
    next_cycle();

    // Single icache read, RAM ready 3 cycles after command
    lat = 3;
    i_txn(32'h40);
    if (clog.size() > 0) chk("single_latency", clog[clog.size()-1].cyc - last_i_req, 32'd4);
    else fail_now("single_no_log");

    // dWEN and dREN together: write wins
    lat = 1;
    d_txn(1, 1, 32'h10, 32'hA5A5F00D);

    // Contention: write first, then icache after the bubble
    n0 = clog.size();
    fork
      i_txn(32'h44);
      d_txn(1, 0, 32'h80, 32'h12345678);
    join
    if (clog.size() - n0 == 2) begin
      chk("contention_first_d", {31'h0, clog[n0].isd}, 32'h1);
      chk("contention_second_i", {31'h0, clog[n0+1].isd}, 32'h0);
      chk("contention_gap", clog[n0+1].cyc - clog[n0].cyc, 32'd3);
    end else fail_now("contention_count");

    // Starvation guard
    lat = 0;
    n0 = clog.size();
    fork
      i_txn(32'h1100);
      repeat (5) d_txn(0, 1, 32'h2100, 32'h0);
    join
    if (clog.size() - n0 == 6) begin
      for (int k = 0; k < 6; k++) chk("starve_seq", {31'h0, clog[n0+k].isd}, {31'h0, expv[k]});
    end else fail_now("starve_count");

    // Abort with ram_ready in the drop cycle
    lat = 10;
    daddr = 32'h2040; dREN = 1'b1;
    next_cycle();
    @(negedge CLK);
    chk("abort_cmd_on", {31'h0, ramREN}, 32'h1);
    next_cycle();
    dREN = 1'b0; force_ready = 1;
    @(negedge CLK);
    chk("abort_drop_cmd", {30'h0, ramREN, ramWEN}, 32'h0);
    chk("abort_dwait", {31'h0, dwait}, 32'h1);
    next_cycle();
    force_ready = 0;
    @(negedge CLK);
    chk_idle("abort_after");
    next_cycle();

    // Reset held two cycles mid-DGNT
    lat = 20;
    daddr = 32'h2080; dREN = 1'b1;
    next_cycle();
    @(negedge CLK);
    chk("rst_pre_cmd", {31'h0, ramREN}, 32'h1);
    next_cycle();
    RST = 1'b1;
    next_cycle();
    @(negedge CLK);
    chk_idle("rst_hold");
    next_cycle();
    RST = 1'b0; dREN = 1'b0;
    @(negedge CLK);
    chk_idle("rst_release");
    next_cycle();
    @(negedge CLK);
    chk_idle("rst_after");
    next_cycle();

    // Randomised traffic
    rand_lat = 1; noise = 1;
    fork
      repeat (30) begin
        repeat ($urandom_range(0, 3)) next_cycle();
        i_txn(32'h1000 + ($urandom_range(0, 255) << 2));
      end
      repeat (40) begin
        int kind;
        repeat ($urandom_range(0, 3)) next_cycle();
        kind = $urandom_range(0, 2);
        d_txn(kind != 0, kind != 1, 32'h2000 + ($urandom_range(0, 255) << 2), $urandom);
      end
    join
    noise = 0;
    repeat (5) next_cycle();
    chk("iq_drained", iq.size(), 32'h0);
    chk("dq_drained", dq.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
